// File: rtl/rvm_mem_arbiter_if.sv
// Bundle for rvm_mem_arbiter: fetch and data requester handshakes plus the memory port.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface rvm_mem_arbiter_if;
  // Fetch requester
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rsp_valid;

  // Data requester
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_ben;
  logic        d_gnt;
  logic        d_rsp_valid;

  // Shared response
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  // Memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_stall;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_wdata, d_ben,
    input  mem_rdata, mem_error, mem_stall,
    output f_gnt, f_rsp_valid, d_gnt, d_rsp_valid, rsp_rdata, rsp_error,
    output mem_addr, mem_wdata, mem_c_en, mem_b_en
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_wdata, d_ben,
    output mem_rdata, mem_error, mem_stall,
    input  f_gnt, f_rsp_valid, d_gnt, d_rsp_valid, rsp_rdata, rsp_error,
    input  mem_addr, mem_wdata, mem_c_en, mem_b_en
  );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single memory port, one transaction in flight.
// Define RVM_MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data wins.
module rvm_mem_arbiter #(
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  rvm_mem_arbiter_if.slave        arb_if
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  ben_q;
  logic        c_en_q;
  logic        owner_d_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        f_vld_q;
  logic        d_vld_q;
  logic [7:0]  stall_cnt_q;
  logic [7:0]  stall_cnt_d;
`ifdef RVM_MEM_ARB_RR_EN
  logic        last_d_q;
`endif

  logic pick_d;
  logic grant_d;
  logic grant_f;
  logic wd_expire;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef RVM_MEM_ARB_RR_EN
    pick_d = ~last_d_q;
`else
    pick_d = 1'b1;
`endif
    grant_d     = ~reset && (state_q == IDLE) && arb_if.d_req && (~arb_if.f_req || pick_d);
    grant_f     = ~reset && (state_q == IDLE) && arb_if.f_req && ~grant_d;
    stall_cnt_d = stall_cnt_q + 8'd1;
    // Abort in the stalled cycle that brings the count up to the limit.
    wd_expire   = (STALL_LIMIT != 0) && arb_if.mem_stall && (stall_cnt_d == 8'(STALL_LIMIT));
  end

  // NOTE: async reset with non-blocking updates; mem_c_en falls the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      ben_q       <= '0;
      c_en_q      <= 1'b0;
      owner_d_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      f_vld_q     <= 1'b0;
      d_vld_q     <= 1'b0;
      stall_cnt_q <= '0;
`ifdef RVM_MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      f_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d || grant_f) begin
            state_q     <= ACCESS;
            c_en_q      <= 1'b1;
            owner_d_q   <= grant_d;
            stall_cnt_q <= '0;
            addr_q      <= grant_d ? arb_if.d_addr  : arb_if.f_addr;
            wdata_q     <= grant_d ? arb_if.d_wdata : 32'd0;
            ben_q       <= grant_d ? arb_if.d_ben   : 4'd0;
`ifdef RVM_MEM_ARB_RR_EN
            last_d_q    <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (arb_if.mem_stall) begin
            stall_cnt_q <= stall_cnt_d;
          end
          if (~arb_if.mem_stall || wd_expire) begin
            state_q <= IDLE;
            c_en_q  <= 1'b0;
            rdata_q <= arb_if.mem_stall ? 32'd0 : arb_if.mem_rdata;
            err_q   <= arb_if.mem_stall | arb_if.mem_error;
            f_vld_q <= ~owner_d_q;
            d_vld_q <= owner_d_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_if.f_gnt       = grant_f;
  assign arb_if.d_gnt       = grant_d;
  assign arb_if.f_rsp_valid = f_vld_q;
  assign arb_if.d_rsp_valid = d_vld_q;
  assign arb_if.rsp_rdata   = rdata_q;
  assign arb_if.rsp_error   = err_q;
  assign arb_if.mem_addr    = addr_q;
  assign arb_if.mem_wdata   = wdata_q;
  assign arb_if.mem_b_en    = ben_q;
  assign arb_if.mem_c_en    = c_en_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Scoreboard bench for rvm_mem_arbiter: a negedge monitor models grants, plays the memory,
// and checks responses against entries queued at grant time.
module tb_rvm_mem_arbiter;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rvm_mem_arbiter_if bus();

  rvm_mem_arbiter #(.STALL_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic [31:0] rdata;
    logic        err;
    logic        merr;
    logic        chk_rdata;
    int          exp_cyc;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Per-requester memory behaviour for the next grant
  int   f_stall = 0, d_stall = 0;
  logic f_err = 1'b0, d_err = 1'b0;

  // Monitor-owned model state
  int   stall_left   = 0;
  bit   busy         = 1'b0;
  bit   last_d       = 1'b0;
  int   grant_cnt    = 0;
  int   last_gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    txn_t t;
    logic pick_d, exp_d, exp_f;
    int   st;
    if (reset) begin
      sb.delete();
      busy = 1'b0; stall_left = 0; last_d = 1'b0;
      bus.mem_stall = 1'b0; bus.mem_error = 1'b0; bus.mem_rdata = '0;
      check("gnt_in_reset", {bus.f_gnt, bus.d_gnt}, 0);
      check("c_en_in_reset", bus.mem_c_en, 0);
    end else begin
      if (bus.f_rsp_valid || bus.d_rsp_valid) begin
        check("rsp_exclusive", bus.f_rsp_valid & bus.d_rsp_valid, 0);
        if (sb.size() == 0) begin
          check("spurious_rsp", {bus.f_rsp_valid, bus.d_rsp_valid}, 0);
        end else begin
          t = sb.pop_front();
          check("rsp_owner_d", bus.d_rsp_valid, t.is_d);
          check("rsp_cycle", cyc, t.exp_cyc);
          check("rsp_error", bus.rsp_error, t.err);
          if (t.chk_rdata) check("rsp_rdata", bus.rsp_rdata, t.rdata);
          busy = 1'b0;
        end
      end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
        check("rsp_timeout", cyc, sb[0].exp_cyc);
        void'(sb.pop_front());
        busy = 1'b0;
      end

      check("mem_c_en", bus.mem_c_en, busy);
      if (busy && bus.mem_c_en) begin
        check("mem_addr", bus.mem_addr, sb[0].addr);
        check("mem_wdata", bus.mem_wdata, sb[0].wdata);
        check("mem_b_en", bus.mem_b_en, sb[0].ben);
        if (stall_left > 0) begin
          bus.mem_stall = 1'b1; bus.mem_error = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
          stall_left--;
        end else begin
          bus.mem_stall = 1'b0; bus.mem_error = sb[0].merr; bus.mem_rdata = mem_word(sb[0].addr);
        end
      end else begin
        bus.mem_stall = 1'b0; bus.mem_error = 1'b0;
      end

`ifdef RVM_MEM_ARB_RR_EN
      pick_d = ~last_d;
`else
      pick_d = 1'b1;
`endif
      exp_d = ~busy && bus.d_req && (~bus.f_req || pick_d);
      exp_f = ~busy && bus.f_req && ~exp_d;
      if (bus.f_req || bus.d_req || bus.f_gnt || bus.d_gnt) begin
        check("d_gnt", bus.d_gnt, exp_d);
        check("f_gnt", bus.f_gnt, exp_f);
      end
      if (exp_d || exp_f) begin
        st        = exp_d ? d_stall : f_stall;
        t.is_d    = exp_d;
        t.addr    = exp_d ? bus.d_addr  : bus.f_addr;
        t.wdata   = exp_d ? bus.d_wdata : 32'd0;
        t.ben     = exp_d ? bus.d_ben   : 4'd0;
        t.merr    = exp_d ? d_err : f_err;
        if (LIMIT != 0 && st >= int'(LIMIT)) begin
          t.err = 1'b1; t.rdata = 32'd0; t.chk_rdata = 1'b1; t.exp_cyc = cyc + int'(LIMIT) + 1;
        end else begin
          t.err = t.merr; t.rdata = mem_word(t.addr); t.chk_rdata = (t.ben == 4'd0);
          t.exp_cyc = cyc + st + 2;
        end
        sb.push_back(t);
        busy = 1'b1; stall_left = st; last_d = exp_d;
        grant_cnt++; last_gnt_cyc = cyc;
      end
    end
  end

  task automatic wait_grants(input int target);
    for (int i = 0; i < 200 && grant_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    if (grant_cnt < target) check("gnt_timeout", grant_cnt, target);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_f(input logic [31:0] a, input int st, input logic e);
    int g0 = grant_cnt;
    f_addr_set(a); f_stall = st; f_err = e; bus.f_req = 1'b1;
    wait_grants(g0 + 1);
    @(posedge clk); #1 bus.f_req = 1'b0;
  endtask

  task automatic f_addr_set(input logic [31:0] a);
    bus.f_addr = a;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                         input int st, input logic e);
    int g0 = grant_cnt;
    bus.d_addr = a; bus.d_wdata = w; bus.d_ben = b; d_stall = st; d_err = e; bus.d_req = 1'b1;
    wait_grants(g0 + 1);
    @(posedge clk); #1 bus.d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int g0, c0;
    reset = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'h40;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_ben = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_c_en", bus.mem_c_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_b_en", bus.mem_b_en, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_rsp_valid", {bus.f_rsp_valid, bus.d_rsp_valid}, 0);
    check("rst_f_gnt", bus.f_gnt, 0);
    @(posedge clk); #1;
    bus.f_req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    issue_f(32'h100, 0, 1'b0);                          drain();
    issue_d(32'h2000, 32'h1234_5678, 4'hF, 3, 1'b0);    drain();
    issue_d(32'h3004, 32'h0, 4'h0, 0, 1'b1);            drain();
    issue_d(32'h44, 32'h0, 4'h0, 2, 1'b0);              drain();
    issue_d(32'h1003, 32'hA5A5_0F0F, 4'b0110, 1, 1'b0); drain();
    issue_f(32'h500, 100, 1'b0);                        drain();

    // Both requesters held: order follows the arbitration model, one grant every 2 cycles
    bus.f_addr = 32'h600; f_stall = 0; f_err = 1'b0;
    bus.d_addr = 32'h700; bus.d_wdata = 32'h0; bus.d_ben = 4'h0; d_stall = 0; d_err = 1'b0;
    g0 = grant_cnt;
    bus.f_req = 1'b1; bus.d_req = 1'b1;
    wait_grants(g0 + 1);
    c0 = last_gnt_cyc;
    wait_grants(g0 + 6);
    check("b2b_span", last_gnt_cyc - c0, 10);
    @(posedge clk); #1;
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    drain();

    // Reset in the middle of a stalled store
    issue_d(32'h800, 32'hCAFE_F00D, 4'hF, 50, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_mid_c_en", bus.mem_c_en, 0);
    check("rst_mid_b_en", bus.mem_b_en, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue_f(32'h900, 0, 1'b0);                          drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
